// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package control_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  // Major opcodes.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Branch funct3 values.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU operations.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // Immediate formats.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // PC source select.
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Writeback source select.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Fields decoded from the instruction register.
  typedef struct packed {
    logic       legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic [3:0] alu_op;
    logic       alu_src;
    logic [2:0] imm_sel;
  } dec_t;

  // ALU op for OP / OP-IMM. alt is funct7[5]; it only means SUB for the register form.
  function automatic logic [3:0] arith_alu_op(input logic [2:0] funct3, input logic alt,
                                              input logic is_reg);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into control fields and legality.
module instr_decode
  import control_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign alt    = ir_i[30];

  // Register indices and immediates are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

  // Opcode/funct3 decode; anything unrecognised stays illegal.
  always_comb begin
    dec_o         = '0;
    dec_o.alu_op  = ALU_ADD;
    dec_o.imm_sel = IMM_I;
    case (opcode)
      OPC_OP: begin
        dec_o.legal   = 1'b1;
        dec_o.alu_op  = arith_alu_op(funct3, alt, 1'b1);
        dec_o.alu_src = 1'b0;
      end
      OPC_OP_IMM: begin
        dec_o.legal   = 1'b1;
        dec_o.alu_op  = arith_alu_op(funct3, alt, 1'b0);
        dec_o.alu_src = 1'b1;
      end
      OPC_LUI: begin
        dec_o.legal   = 1'b1;
        dec_o.alu_op  = ALU_PASSB;
        dec_o.alu_src = 1'b1;
        dec_o.imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        dec_o.legal   = 1'b1;
        dec_o.alu_src = 1'b1;
        dec_o.imm_sel = IMM_U;
      end
      OPC_JAL: begin
        dec_o.legal   = 1'b1;
        dec_o.is_jal  = 1'b1;
        dec_o.alu_src = 1'b1;
        dec_o.imm_sel = IMM_J;
      end
      OPC_JALR: begin
        dec_o.legal   = (funct3 == 3'b000);
        dec_o.is_jalr = 1'b1;
        dec_o.alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec_o.is_branch = 1'b1;
        dec_o.alu_op    = ALU_SUB;
        dec_o.alu_src   = 1'b0;
        dec_o.imm_sel   = IMM_B;
      end
      OPC_LOAD: begin
        dec_o.legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        dec_o.is_load = 1'b1;
        dec_o.alu_src = 1'b1;
      end
      OPC_STORE: begin
        dec_o.legal    = (funct3 <= 3'b010);
        dec_o.is_store = 1'b1;
        dec_o.alu_src  = 1'b1;
        dec_o.imm_sel  = IMM_S;
      end
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_multicycle.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with an internal
// instruction register and an absorbing TRAP state for illegal instructions.
// Define CTRL_TIMEOUT_EN to trap when a FETCH or MEM wait reaches TIMEOUT_CYCLES.
module control_multicycle
  import control_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned ALUCTRL_WIDTH  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] instr_i,
  input  logic                     instr_valid_i,
  input  logic                     mem_ready_i,
  input  logic                     eq_i,
  input  logic                     lt_i,
  input  logic                     ltu_i,
  output logic                     instr_req_o,
  output logic                     regWrite_en_o,
  output logic [ALUCTRL_WIDTH-1:0] ALUctrl_o,
  output logic                     ALUsrc_o,
  output logic [2:0]               IMMctrl_o,
  output logic [1:0]               PCsrc_o,
  output logic                     pc_en_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [2:0]               mem_size_o,
  output logic [1:0]               resultSrc_o,
  output logic                     illegal_o
);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ir_q, ir_d;
  dec_t                     dec;
  logic [2:0]               funct3;
  logic                     br_taken;

  assign funct3 = ir_q[14:12];

  instr_decode u_instr_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            waiting;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Branch condition from the ALU flags of the current EXEC cycle.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = eq_i;
      F3_BNE:  br_taken = ~eq_i;
      F3_BLT:  br_taken = lt_i;
      F3_BGE:  br_taken = ~lt_i;
      F3_BLTU: br_taken = ltu_i;
      F3_BGEU: br_taken = ~ltu_i;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and instruction register capture.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = DECODE;
        end
      end
      DECODE: state_d = dec.legal ? EXEC : TRAP;
      EXEC: begin
        if (dec.is_load || dec.is_store) state_d = MEM;
        else if (dec.is_branch)          state_d = FETCH;
        else                             state_d = WB;
      end
      MEM: begin
        if (mem_ready_i) state_d = dec.is_store ? FETCH : WB;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
`ifdef CTRL_TIMEOUT_EN
    // Counter only runs while stalled; any state change leaves it cleared.
    waiting    = ((state_q == FETCH) && !instr_valid_i) || ((state_q == MEM) && !mem_ready_i);
    wait_cnt_d = '0;
    if (waiting) begin
      if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) state_d = TRAP;
      else                                          wait_cnt_d = wait_cnt_q + 1'b1;
    end
`endif
  end

  // State, IR and wait counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      ir_q    <= '0;
`ifdef CTRL_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef CTRL_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Output decode from state and IR; everything is forced low while reset is held.
  always_comb begin
    instr_req_o   = 1'b0;
    regWrite_en_o = 1'b0;
    ALUctrl_o     = '0;
    ALUsrc_o      = 1'b0;
    IMMctrl_o     = 3'b000;
    PCsrc_o       = PC_PLUS4;
    pc_en_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_size_o    = 3'b000;
    resultSrc_o   = RES_ALU;
    illegal_o     = 1'b0;
    if (!rst_i) begin
      case (state_q)
        FETCH:  instr_req_o = 1'b1;
        DECODE: IMMctrl_o = dec.imm_sel;
        EXEC: begin
          IMMctrl_o = dec.imm_sel;
          ALUctrl_o = ALUCTRL_WIDTH'(dec.alu_op);
          ALUsrc_o  = dec.alu_src;
          if (dec.is_branch) begin
            pc_en_o = 1'b1;
            PCsrc_o = br_taken ? PC_IMM : PC_PLUS4;
          end
        end
        MEM: begin
          IMMctrl_o  = dec.imm_sel;
          mem_req_o  = 1'b1;
          mem_we_o   = dec.is_store;
          mem_size_o = funct3;
          // A store retires in the ack cycle, so the PC strobe waits for the ack.
          pc_en_o    = dec.is_store && mem_ready_i;
        end
        WB: begin
          IMMctrl_o     = dec.imm_sel;
          regWrite_en_o = 1'b1;
          pc_en_o       = 1'b1;
          if (dec.is_jal)       PCsrc_o = PC_IMM;
          else if (dec.is_jalr) PCsrc_o = PC_ALU;
          if (dec.is_load)                    resultSrc_o = RES_MEM;
          else if (dec.is_jal || dec.is_jalr) resultSrc_o = RES_PC4;
        end
        TRAP:    illegal_o = 1'b1;
        default: instr_req_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multicycle.sv
// Directed bench for control_multicycle. Outputs are packed into one vector:
// {instr_req, regWrite, ALUctrl[3:0], ALUsrc, IMM[2:0], PCsrc[1:0], pc_en,
//  mem_req, mem_we, mem_size[2:0], resultSrc[1:0], illegal}
module tb_control_multicycle;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i, mem_ready_i, eq_i, lt_i, ltu_i;
  logic        instr_req_o, regWrite_en_o, ALUsrc_o, pc_en_o, mem_req_o, mem_we_o, illegal_o;
  logic [3:0]  ALUctrl_o;
  logic [2:0]  IMMctrl_o, mem_size_o;
  logic [1:0]  PCsrc_o, resultSrc_o;

  logic [20:0] outs;
  logic [20:0] exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [20:0] V_FETCH = 21'b1_0_0000_0_000_00_0_0_0_000_00_0;
  localparam logic [20:0] V_ZERO  = 21'b0_0_0000_0_000_00_0_0_0_000_00_0;
  localparam logic [20:0] V_TRAP  = 21'b0_0_0000_0_000_00_0_0_0_000_00_1;
  localparam logic [20:0] V_LWMEM = 21'b0_0_0000_0_000_00_0_1_0_010_00_0;

  control_multicycle dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .mem_ready_i   (mem_ready_i),
    .eq_i          (eq_i),
    .lt_i          (lt_i),
    .ltu_i         (ltu_i),
    .instr_req_o   (instr_req_o),
    .regWrite_en_o (regWrite_en_o),
    .ALUctrl_o     (ALUctrl_o),
    .ALUsrc_o      (ALUsrc_o),
    .IMMctrl_o     (IMMctrl_o),
    .PCsrc_o       (PCsrc_o),
    .pc_en_o       (pc_en_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_size_o    (mem_size_o),
    .resultSrc_o   (resultSrc_o),
    .illegal_o     (illegal_o)
  );

  assign outs = {instr_req_o, regWrite_en_o, ALUctrl_o, ALUsrc_o, IMMctrl_o, PCsrc_o, pc_en_o,
                 mem_req_o, mem_we_o, mem_size_o, resultSrc_o, illegal_o};

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present an instruction for one FETCH cycle; returns with the DUT in DECODE.
  task automatic issue(input logic [31:0] ins);
    instr_i       = ins;
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    instr_i       = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    exp = V_ZERO; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL reset_held got %b exp %b", outs, exp); end
    rst_i = 1'b0;
    #1;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL reset_fetch got %b exp %b", outs, exp); end
  endtask

  task automatic test_sub();
    issue(32'h4020_81B3);
    exp = V_ZERO; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sub_decode got %b exp %b", outs, exp); end
    step();
    exp = 21'b0_0_0001_0_000_00_0_0_0_000_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sub_exec got %b exp %b", outs, exp); end
    step();
    exp = 21'b0_1_0000_0_000_00_1_0_0_000_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sub_wb got %b exp %b", outs, exp); end
    step();
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sub_refetch got %b exp %b", outs, exp); end
  endtask

  // addi (bit30 set, still ADD), srai, lui, jal, jalr: EXEC then WB vectors.
  task automatic test_imm_jump();
    logic [31:0] ins [5];
    logic [20:0] ex  [5];
    logic [20:0] wb  [5];
    ins[0] = 32'hFFF0_0093; ex[0] = 21'b0_0_0000_1_000_00_0_0_0_000_00_0;
    wb[0]  = 21'b0_1_0000_0_000_00_1_0_0_000_00_0;
    ins[1] = 32'h4030_D193; ex[1] = 21'b0_0_0111_1_000_00_0_0_0_000_00_0;
    wb[1]  = 21'b0_1_0000_0_000_00_1_0_0_000_00_0;
    ins[2] = 32'h1234_52B7; ex[2] = 21'b0_0_1010_1_011_00_0_0_0_000_00_0;
    wb[2]  = 21'b0_1_0000_0_011_00_1_0_0_000_00_0;
    ins[3] = 32'h0080_00EF; ex[3] = 21'b0_0_0000_1_100_00_0_0_0_000_00_0;
    wb[3]  = 21'b0_1_0000_0_100_01_1_0_0_000_10_0;
    ins[4] = 32'h0001_00E7; ex[4] = 21'b0_0_0000_1_000_00_0_0_0_000_00_0;
    wb[4]  = 21'b0_1_0000_0_000_10_1_0_0_000_10_0;
    for (int i = 0; i < 5; i++) begin
      issue(ins[i]);
      step();
      n_tests++;
      if (outs !== ex[i]) begin
        n_fail++; $display("FAIL imm_exec[%0d] got %b exp %b", i, outs, ex[i]);
      end
      step();
      n_tests++;
      if (outs !== wb[i]) begin
        n_fail++; $display("FAIL imm_wb[%0d] got %b exp %b", i, outs, wb[i]);
      end
      step();
    end
  endtask

  task automatic test_load();
    mem_ready_i = 1'b0;
    issue(32'h0081_2283);
    step();
    exp = 21'b0_0_0000_1_000_00_0_0_0_000_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL lw_exec got %b exp %b", outs, exp); end
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready_i = 1'b1;
      #1;
      exp = V_LWMEM; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL lw_mem[%0d] got %b exp %b", k, outs, exp); end
      step();
    end
    mem_ready_i = 1'b0;
    exp = 21'b0_1_0000_0_000_00_1_0_0_000_01_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL lw_wb got %b exp %b", outs, exp); end
    step();
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL lw_refetch got %b exp %b", outs, exp); end
  endtask

  task automatic test_store();
    mem_ready_i = 1'b1;
    issue(32'h0051_2223);
    exp = 21'b0_0_0000_0_001_00_0_0_0_000_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sw_decode got %b exp %b", outs, exp); end
    step();
    exp = 21'b0_0_0000_1_001_00_0_0_0_000_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sw_exec got %b exp %b", outs, exp); end
    step();
    exp = 21'b0_0_0000_0_001_00_1_1_1_010_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sw_mem got %b exp %b", outs, exp); end
    step();
    mem_ready_i = 1'b0;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL sw_refetch got %b exp %b", outs, exp); end
  endtask

  task automatic test_branch();
    logic [31:0] ins [5];
    logic [2:0]  flg [5];   // {eq, lt, ltu}
    logic [1:0]  pcs [5];
    ins[0] = 32'h0020_8863; flg[0] = 3'b100; pcs[0] = 2'b01;  // beq taken
    ins[1] = 32'h0020_8863; flg[1] = 3'b000; pcs[1] = 2'b00;  // beq not taken
    ins[2] = 32'h0020_E863; flg[2] = 3'b001; pcs[2] = 2'b01;  // bltu taken
    ins[3] = 32'h0020_D863; flg[3] = 3'b010; pcs[3] = 2'b00;  // bge not taken
    ins[4] = 32'h0020_9863; flg[4] = 3'b000; pcs[4] = 2'b01;  // bne taken
    for (int i = 0; i < 5; i++) begin
      {eq_i, lt_i, ltu_i} = flg[i];
      issue(ins[i]);
      exp = 21'b0_0_0000_0_010_00_0_0_0_000_00_0; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL br_decode[%0d] got %b exp %b", i, outs, exp); end
      step();
      exp = {1'b0, 1'b0, 4'b0001, 1'b0, 3'b010, pcs[i], 1'b1, 8'b0}; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL br_exec[%0d] got %b exp %b", i, outs, exp); end
      step();
      exp = V_FETCH; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL br_refetch[%0d] got %b exp %b", i, outs, exp); end
    end
    {eq_i, lt_i, ltu_i} = 3'b000;
  endtask

  task automatic test_illegal();
    issue(32'h0000_007F);
    exp = V_ZERO; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL ill_decode got %b exp %b", outs, exp); end
    step();
    for (int k = 0; k < 10; k++) begin
      instr_valid_i = 1'b1;
      mem_ready_i   = 1'b1;
      #1;
      exp = V_TRAP; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL ill_trap[%0d] got %b exp %b", k, outs, exp); end
      step();
    end
    instr_valid_i = 1'b0;
    mem_ready_i   = 1'b0;
    rst_i         = 1'b1;
    #1;
    exp = V_ZERO; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL ill_rst_held got %b exp %b", outs, exp); end
    step();
    rst_i = 1'b0;
    #1;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL ill_rst_fetch got %b exp %b", outs, exp); end
    // Load opcode with reserved funct3 011.
    issue(32'h0081_3283);
    step();
    exp = V_TRAP; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL ill_funct3 got %b exp %b", outs, exp); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_mem();
    mem_ready_i = 1'b0;
    issue(32'h0081_2283);
    step();
    step();
    exp = V_LWMEM; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL rstmem_mem got %b exp %b", outs, exp); end
    rst_i = 1'b1;
    #1;
    exp = V_ZERO; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL rstmem_held got %b exp %b", outs, exp); end
    step();
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL rstmem_fetch got %b exp %b", outs, exp); end
    step();
    mem_ready_i = 1'b0;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL rstmem_ready_ignored got %b exp %b", outs, exp); end
  endtask

  task automatic test_back_to_back();
    mem_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = V_FETCH; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL b2b_wait[%0d] got %b exp %b", k, outs, exp); end
      step();
    end
    mem_ready_i = 1'b0;
    issue(32'h0020_81B3);
    step();
    exp = V_ZERO; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL b2b_add_exec got %b exp %b", outs, exp); end
    step();
    exp = 21'b0_1_0000_0_000_00_1_0_0_000_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL b2b_add_wb got %b exp %b", outs, exp); end
    step();
    issue(32'h0051_2223);
    step();
    mem_ready_i = 1'b1;
    step();
    exp = 21'b0_0_0000_0_001_00_1_1_1_010_00_0; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL b2b_sw_mem got %b exp %b", outs, exp); end
    step();
    mem_ready_i = 1'b0;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL b2b_refetch got %b exp %b", outs, exp); end
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout();
    mem_ready_i = 1'b0;
    issue(32'h0081_2283);
    step();
    step();
    for (int k = 0; k < 15; k++) begin
      exp = V_LWMEM; n_tests++;
      if (outs !== exp) begin n_fail++; $display("FAIL to_wait[%0d] got %b exp %b", k, outs, exp); end
      step();
    end
    exp = V_TRAP; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL to_trap got %b exp %b", outs, exp); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    exp = V_FETCH; n_tests++;
    if (outs !== exp) begin n_fail++; $display("FAIL to_rst_fetch got %b exp %b", outs, exp); end
  endtask
`endif

  initial begin
    rst_i         = 1'b1;
    instr_i       = 32'h0;
    instr_valid_i = 1'b0;
    mem_ready_i   = 1'b0;
    eq_i          = 1'b0;
    lt_i          = 1'b0;
    ltu_i         = 1'b0;
    test_reset();
    test_sub();
    test_imm_jump();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
